// File: rtl/pll_ce_pkg.sv
// pll_ce_pkg: shared types and helpers for the pll_ce_gen slice.
//   state_e     : lock-qualification FSM states
//   lock_cnt_w  : width of the lock-qualification counter
//   ch_w        : width of the channel-index port (never below 1)
//   CH_IDX_W    : index width needed for the largest supported channel count (16)
//   ACC_W_DEF   : default numerator/denominator/accumulator width
package pll_ce_pkg;

  localparam int unsigned CH_IDX_W  = 4;
  localparam int unsigned ACC_W_DEF = 16;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    COUNT,
    RUN
  } state_e;

  function automatic int unsigned lock_cnt_w(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

  function automatic int unsigned ch_w(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/pll_ce_acc.sv
// pll_ce_acc: one fractional clock-enable channel (Bresenham accumulator).
// Produces single-cycle pulses at an average rate of num/den per clock.
// Optional macro PLL_CE_GEN_MID_EN adds ce_mid_o, a pulse when the accumulator
// crosses den/2 without wrapping (half-period phase enable).
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i          : accumulate this cycle; when low acc is cleared and ce is 0
//   we_i          : load num_i/den_i, clear acc, ce forced low
//   num_i, den_i  : new ratio
//   ce_o          : registered clock-enable pulse
//   ce_mid_o      : registered mid-period pulse (PLL_CE_GEN_MID_EN only)
module pll_ce_acc
  import pll_ce_pkg::*;
#(
  parameter int unsigned ACC_W   = ACC_W_DEF,
  parameter int unsigned DEF_NUM = 1,
  parameter int unsigned DEF_DEN = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [ACC_W-1:0] num_i,
  input  logic [ACC_W-1:0] den_i,
`ifdef PLL_CE_GEN_MID_EN
  output logic             ce_mid_o,
`endif
  output logic             ce_o
);

  logic [ACC_W-1:0] num_q, num_d;
  logic [ACC_W-1:0] den_q, den_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ce_q, ce_d;
  logic [ACC_W:0]   sum;
`ifdef PLL_CE_GEN_MID_EN
  logic [ACC_W-1:0] half;
  logic             ce_mid_q, ce_mid_d;
`endif

  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, num_q};
    num_d = num_q;
    den_d = den_q;
    acc_d = acc_q;
    ce_d  = 1'b0;
`ifdef PLL_CE_GEN_MID_EN
    half     = den_q >> 1;
    ce_mid_d = 1'b0;
`endif
    if (we_i) begin
      num_d = num_i;
      den_d = den_i;
      acc_d = '0;
    end else if (!en_i || (den_q == '0)) begin
      acc_d = '0;
    end else if (num_q >= den_q) begin
      // Saturated ratio: pulse every cycle. acc is 0 here (cleared on every
      // load/entry), so holding it keeps acc below den without a modulo.
      ce_d = 1'b1;
    end else if (sum >= {1'b0, den_q}) begin
      // acc < den and num < den, so sum - den < den fits in ACC_W bits.
      ce_d  = 1'b1;
      acc_d = sum[ACC_W-1:0] - den_q;
    end else begin
      acc_d = sum[ACC_W-1:0];
`ifdef PLL_CE_GEN_MID_EN
      ce_mid_d = (acc_q < half) && (sum >= {1'b0, half}) && (den_q >= ACC_W'(2));
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      num_q <= ACC_W'(DEF_NUM);
      den_q <= ACC_W'(DEF_DEN);
      acc_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      num_q <= num_d;
      den_q <= den_d;
      acc_q <= acc_d;
      ce_q  <= ce_d;
    end
  end

`ifdef PLL_CE_GEN_MID_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ce_mid_q <= 1'b0;
    else         ce_mid_q <= ce_mid_d;
  end

  assign ce_mid_o = ce_mid_q;
`endif

  assign ce_o = ce_q;

endmodule

// File: rtl/pll_ce_gen.sv
// pll_ce_gen: multi-channel fractional clock-enable generator on one PLL clock.
// Enables start once locked_in has been stable for LOCK_CYCLES cycles; the
// downstream core reset is released in the same cycle.
// Optional macro PLL_CE_GEN_MID_EN adds the ce_mid output.
//   refclk    : PLL output clock (only clock)
//   rst_n     : asynchronous active-low reset
//   locked_in : PLL lock, asynchronous (2-flop synchronised here)
//   cfg_we    : write strobe for one channel's ratio
//   cfg_ch    : channel index (out-of-range writes ignored)
//   cfg_num   : numerator
//   cfg_den   : denominator
//   ce        : per-channel clock-enable pulses
//   ce_mid    : per-channel mid-period pulses (PLL_CE_GEN_MID_EN only)
//   core_rst  : synchronous active-high reset for the core
//   running   : high while in RUN
module pll_ce_gen
  import pll_ce_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned ACC_W       = ACC_W_DEF,
  parameter int unsigned LOCK_CYCLES = 1024,
  parameter int unsigned DEF_NUM     = 1,
  parameter int unsigned DEF_DEN     = 4
) (
  input  logic                      refclk,
  input  logic                      rst_n,
  input  logic                      locked_in,
  input  logic                      cfg_we,
  input  logic [ch_w(NUM_CH)-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]          cfg_num,
  input  logic [ACC_W-1:0]          cfg_den,
  output logic [NUM_CH-1:0]         ce,
`ifdef PLL_CE_GEN_MID_EN
  output logic [NUM_CH-1:0]         ce_mid,
`endif
  output logic                      core_rst,
  output logic                      running
);

  localparam int unsigned      CH_W     = ch_w(NUM_CH);
  localparam int unsigned      CNT_W    = lock_cnt_w(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  logic             sync1_q, lk_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             core_rst_q, running_q;
  logic             acc_en;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      lk_q    <= 1'b0;
    end else begin
      sync1_q <= locked_in;
      lk_q    <= sync1_q;
    end
  end

  // cnt counts cycles with lk high, so the WAIT_LOCK->COUNT transition is
  // already the first qualified cycle and RUN follows LOCK_CYCLES of them.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lk_q) begin
          if (LOCK_CYCLES <= 1) begin
            state_d = RUN;
          end else begin
            state_d = COUNT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      COUNT: begin
        if (!lk_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!lk_q) state_d = WAIT_LOCK;
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_LOCK;
      cnt_q      <= '0;
      core_rst_q <= 1'b1;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      core_rst_q <= (state_d != RUN);
      running_q  <= (state_d == RUN);
    end
  end

  // Accumulate only while staying in RUN; entering RUN or dropping out of it
  // clears every accumulator and silences ce.
  assign acc_en = (state_q == RUN) && (state_d == RUN);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;
    assign sel = cfg_we && (cfg_ch == CH_W'(i));

    pll_ce_acc #(
      .ACC_W  (ACC_W),
      .DEF_NUM(DEF_NUM),
      .DEF_DEN(DEF_DEN)
    ) u_acc (
      .clk_i   (refclk),
      .rst_ni  (rst_n),
      .en_i    (acc_en),
      .we_i    (sel),
      .num_i   (cfg_num),
      .den_i   (cfg_den),
`ifdef PLL_CE_GEN_MID_EN
      .ce_mid_o(ce_mid[i]),
`endif
      .ce_o    (ce[i])
    );
  end

  assign core_rst = core_rst_q;
  assign running  = running_q;

endmodule
